// File: rtl/core_pkg.sv
// Shared definitions for the RV32I fetch stage.
//   WORD_SIZE     : width of PC, addresses and instructions
//   INSTR_BYTES   : PC increment per sequential instruction
//   fetch_state_t : fetch FSM states
package core_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    TRAP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory req/ack channel and the
// valid/ready channel towards decode.
//   master : the fetch unit (drives imem_req/imem_addr and the if_* payload)
//   slave  : memory + decode side (drives imem_ack/imem_rdata and if_ready)
interface fetch_pc_unit_if #(
  parameter int WORD_SIZE = 32
) ();

  logic                 imem_req;
  logic [WORD_SIZE-1:0] imem_addr;
  logic                 imem_ack;
  logic [WORD_SIZE-1:0] imem_rdata;
  logic                 if_valid;
  logic                 if_ready;
  logic [WORD_SIZE-1:0] if_pc;
  logic [WORD_SIZE-1:0] if_instr;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_ack, imem_rdata, if_ready
  );

endinterface

// File: rtl/next_pc_sel.sv
// Combinational redirect selector.
//   Inputs : jalr/br redirect pulses and targets, pending redirect, current pc
//   Outputs: next_pc        - redirect target if an aligned redirect is present,
//                             else the pending target, else pc
//            redirect_hit   - an aligned redirect is present this cycle
//            misaligned_hit - the selected redirect target is not word-aligned
module next_pc_sel #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 jalr_valid,
  input  logic [WORD_SIZE-1:0] jalr_target,
  input  logic                 br_valid,
  input  logic [WORD_SIZE-1:0] br_target,
  input  logic                 pend_valid,
  input  logic [WORD_SIZE-1:0] pend_target,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] next_pc,
  output logic                 redirect_hit,
  output logic                 misaligned_hit
);

  logic [WORD_SIZE-1:0] sel_target;
  logic                 any_redirect;

  always_comb begin
    // JALR wins when both redirects fire in the same cycle.
    sel_target     = jalr_valid ? jalr_target : br_target;
    any_redirect   = jalr_valid | br_valid;
    redirect_hit   = any_redirect & (sel_target[1:0] == 2'b00);
    misaligned_hit = any_redirect & (sel_target[1:0] != 2'b00);
    if (redirect_hit)
      next_pc = sel_target;
    else if (pend_valid)
      next_pc = pend_target;
    else
      next_pc = pc;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// RV32I program counter and instruction fetch stage.
//   clk, reset_n            : clock, asynchronous active-low reset
//   jalr_valid/jalr_target  : JALR redirect pulse and target
//   br_valid/br_target      : taken branch/JAL redirect pulse and target
//   bus (master)            : imem req/ack fetch channel, if_* channel to decode
//   misaligned              : sticky flag, a redirect target was not word-aligned
module fetch_pc_unit #(
  parameter int                   WORD_SIZE = core_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 jalr_valid,
  input  logic [WORD_SIZE-1:0] jalr_target,
  input  logic                 br_valid,
  input  logic [WORD_SIZE-1:0] br_target,
  fetch_pc_unit_if.master      bus,
  output logic                 misaligned
);

  import core_pkg::*;

  fetch_state_t         state;
  logic [WORD_SIZE-1:0] pc;
  logic                 pend_valid;
  logic [WORD_SIZE-1:0] pend_target;

  logic [WORD_SIZE-1:0] next_pc;
  logic                 redirect_hit;
  logic                 misaligned_hit;

  next_pc_sel #(.WORD_SIZE(WORD_SIZE)) u_next_pc_sel (
    .jalr_valid     (jalr_valid),
    .jalr_target    (jalr_target),
    .br_valid       (br_valid),
    .br_target      (br_target),
    .pend_valid     (pend_valid),
    .pend_target    (pend_target),
    .pc             (pc),
    .next_pc        (next_pc),
    .redirect_hit   (redirect_hit),
    .misaligned_hit (misaligned_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= START;
      pc            <= RESET_PC;
      pend_valid    <= 1'b0;
      pend_target   <= '0;
      misaligned    <= 1'b0;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
      bus.if_valid  <= 1'b0;
      bus.if_pc     <= '0;
      bus.if_instr  <= '0;
    end else begin
      case (state)
        START: begin
          // A redirect arriving right after reset replaces RESET_PC.
          if (misaligned_hit) begin
            misaligned <= 1'b1;
            state      <= TRAP;
          end else begin
            pc            <= next_pc;
            bus.imem_addr <= next_pc;
            bus.imem_req  <= 1'b1;
            pend_valid    <= 1'b0;
            state         <= FETCH;
          end
        end

        FETCH: begin
          if (!bus.imem_ack) begin
            // Address must stay put until the ack; remember the redirect.
            if (misaligned_hit) begin
              misaligned <= 1'b1;
            end else if (redirect_hit) begin
              pend_valid  <= 1'b1;
              pend_target <= next_pc;
            end
          end else if (misaligned || misaligned_hit) begin
            // Request has completed; safe to stop now.
            misaligned   <= 1'b1;
            pend_valid   <= 1'b0;
            bus.imem_req <= 1'b0;
            state        <= TRAP;
          end else if (redirect_hit || pend_valid) begin
            // Fetched word is on the wrong path: drop it, refetch at target.
            pc            <= next_pc;
            bus.imem_addr <= next_pc;
            pend_valid    <= 1'b0;
          end else begin
            bus.if_pc    <= pc;
            bus.if_instr <= bus.imem_rdata;
            bus.if_valid <= 1'b1;
            bus.imem_req <= 1'b0;
            pc           <= pc + WORD_SIZE'(INSTR_BYTES);
            state        <= OUT;
          end
        end

        OUT: begin
          if (misaligned_hit) begin
            misaligned   <= 1'b1;
            bus.if_valid <= 1'b0;
            state        <= TRAP;
          end else if (redirect_hit) begin
            // Redirect takes the next PC whether or not decode took the word.
            pc            <= next_pc;
            bus.imem_addr <= next_pc;
            bus.imem_req  <= 1'b1;
            bus.if_valid  <= 1'b0;
            state         <= FETCH;
          end else if (bus.if_ready) begin
            bus.imem_addr <= pc;
            bus.imem_req  <= 1'b1;
            bus.if_valid  <= 1'b0;
            state         <= FETCH;
          end
        end

        TRAP: begin
          bus.imem_req <= 1'b0;
          bus.if_valid <= 1'b0;
        end

        default: state <= TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a vector table of fetches plus hand-written
// redirect, trap and wrap-around sequences; accepted if_* words are checked
// against a queue of expected {pc, instr}.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        jalr_valid;
  logic [31:0] jalr_target;
  logic        br_valid;
  logic [31:0] br_target;
  logic        misaligned;

  fetch_pc_unit_if #(.WORD_SIZE(32)) bus ();

  fetch_pc_unit #(.WORD_SIZE(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .jalr_valid  (jalr_valid),
    .jalr_target (jalr_target),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .bus         (bus.master),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          ack_dly;
    int          rdy_dly;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every word decode accepts must be the next expected one.
  always @(negedge clk) begin
    if (reset_n && bus.if_valid && bus.if_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc %h want no output", bus.if_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_pc", bus.if_pc, e.pc);
        check("out_instr", bus.if_instr, e.instr);
      end
    end
  end

  task automatic wait_req(input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    if (!bus.imem_req) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got no imem_req want addr %h", exp_addr);
    end else begin
      check("req_addr", bus.imem_addr, exp_addr);
    end
  endtask

  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] rdata,
                           input int ack_dly, input int rdy_dly);
    wait_req(addr);
    for (int k = 0; k < ack_dly; k++) begin
      step();
      check("addr_hold", bus.imem_addr, addr);
    end
    bus.if_ready   = (rdy_dly == 0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    sb.push_back({addr, rdata});
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    check("if_valid_lat", {31'b0, bus.if_valid}, 32'd1);
    if (rdy_dly > 0) begin
      for (int k = 0; k < rdy_dly; k++) begin
        check("hold_valid", {31'b0, bus.if_valid}, 32'd1);
        check("hold_pc", bus.if_pc, addr);
        check("hold_instr", bus.if_instr, rdata);
        check("hold_no_req", {31'b0, bus.imem_req}, 32'd0);
        step();
      end
      bus.if_ready = 1'b1;
      step();
    end
  endtask

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{addr: 32'h0000_0000, rdata: 32'h0000_0013, ack_dly: 1, rdy_dly: 0};
    vecs[1] = '{addr: 32'h0000_0004, rdata: 32'h0010_0093, ack_dly: 1, rdy_dly: 0};
    vecs[2] = '{addr: 32'h0000_0008, rdata: 32'h0020_0113, ack_dly: 1, rdy_dly: 0};
    vecs[3] = '{addr: 32'h0000_000C, rdata: 32'hDEAD_BEEF, ack_dly: 0, rdy_dly: 3};
    vecs[4] = '{addr: 32'h0000_0010, rdata: 32'hCAFE_F00D, ack_dly: 2, rdy_dly: 0};

    reset_n        = 1'b0;
    jalr_valid     = 1'b0;
    jalr_target    = '0;
    br_valid       = 1'b0;
    br_target      = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.if_ready   = 1'b0;

    repeat (2) step();
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    check("rst_mis", {31'b0, misaligned}, 32'd0);
    check("rst_pc", bus.if_pc, 32'd0);
    check("rst_instr", bus.if_instr, 32'd0);

    reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++)
      fetch_one(vecs[i].addr, vecs[i].rdata, vecs[i].ack_dly, vecs[i].rdy_dly);

    // JALR while the fetch of 0x14 waits for its ack.
    wait_req(32'h14);
    step();
    jalr_valid  = 1'b1;
    jalr_target = 32'h100;
    step();
    jalr_valid  = 1'b0;
    check("jalr_addr_hold", bus.imem_addr, 32'h14);
    step();
    check("jalr_addr_hold2", bus.imem_addr, 32'h14);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1111_1111;
    step();
    bus.imem_ack = 1'b0;
    check("jalr_drop", {31'b0, bus.if_valid}, 32'd0);
    check("jalr_req", {31'b0, bus.imem_req}, 32'd1);
    check("jalr_new_addr", bus.imem_addr, 32'h100);
    step();
    check("jalr_drop2", {31'b0, bus.if_valid}, 32'd0);

    // Both redirects while presenting 0x100 with decode stalled.
    bus.if_ready   = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h2222_2222;
    step();
    bus.imem_ack = 1'b0;
    check("out_valid", {31'b0, bus.if_valid}, 32'd1);
    check("out_pc_100", bus.if_pc, 32'h100);
    jalr_valid  = 1'b1;
    jalr_target = 32'h200;
    br_valid    = 1'b1;
    br_target   = 32'h300;
    step();
    jalr_valid = 1'b0;
    br_valid   = 1'b0;
    check("prio_valid_drop", {31'b0, bus.if_valid}, 32'd0);
    check("prio_addr", bus.imem_addr, 32'h200);
    fetch_one(32'h200, 32'h3333_3333, 0, 0);

    // Branch to the top of the address space, redirect coincides with ack.
    wait_req(32'h204);
    br_valid       = 1'b1;
    br_target      = 32'hFFFF_FFFC;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h4444_4444;
    step();
    br_valid     = 1'b0;
    bus.imem_ack = 1'b0;
    check("br_ack_drop", {31'b0, bus.if_valid}, 32'd0);
    check("br_ack_addr", bus.imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'h5555_5555, 1, 0);
    fetch_one(32'h0000_0000, 32'h6666_6666, 0, 0);

    // Misaligned branch target while the fetch of 0x4 is outstanding.
    wait_req(32'h4);
    br_valid  = 1'b1;
    br_target = 32'h102;
    step();
    br_valid = 1'b0;
    check("mis_req_held", {31'b0, bus.imem_req}, 32'd1);
    check("mis_addr_held", bus.imem_addr, 32'h4);
    step();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h7777_7777;
    step();
    bus.imem_ack = 1'b0;
    check("mis_flag", {31'b0, misaligned}, 32'd1);
    check("trap_req", {31'b0, bus.imem_req}, 32'd0);
    check("trap_valid", {31'b0, bus.if_valid}, 32'd0);
    jalr_valid  = 1'b1;
    jalr_target = 32'h400;
    step();
    jalr_valid = 1'b0;
    repeat (4) step();
    check("trap_ignore_req", {31'b0, bus.imem_req}, 32'd0);
    check("trap_sticky", {31'b0, misaligned}, 32'd1);

    // Reset clears the trap; a redirect in START replaces RESET_PC.
    reset_n = 1'b0;
    #1;
    check("rst2_mis", {31'b0, misaligned}, 32'd0);
    check("rst2_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    reset_n     = 1'b1;
    jalr_valid  = 1'b1;
    jalr_target = 32'h80;
    step();
    jalr_valid = 1'b0;
    check("start_redir_req", {31'b0, bus.imem_req}, 32'd1);
    check("start_redir_addr", bus.imem_addr, 32'h80);
    fetch_one(32'h80, 32'h8888_8888, 1, 0);
    step();

    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch stage of the RV32I core.
- Consumes redirect targets: the JALR target from the JALR adder and the resolved branch/JAL target.
- Issues word fetches to instruction memory over a req/ack handshake.
- Presents {pc, instruction} to decode over a valid/ready handshake.

Parameters:
- WORD_SIZE, 32, width of PC, addresses and instructions.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- jalr_valid  in  1  one-cycle pulse: JALR redirect.
- jalr_target  in  WORD_SIZE  JALR target, bit 0 already cleared.
- br_valid  in  1  one-cycle pulse: taken branch/JAL redirect.
- br_target  in  WORD_SIZE  branch/JAL target.
- imem_req  out  1  fetch request.
- imem_addr  out  WORD_SIZE  fetch address.
- imem_ack  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  WORD_SIZE  fetched instruction.
- if_valid  out  1  if_pc/if_instr valid to decode.
- if_ready  in  1  decode accepts this cycle.
- if_pc  out  WORD_SIZE  PC of presented instruction.
- if_instr  out  WORD_SIZE  presented instruction.
- misaligned  out  1  sticky: redirect target not word-aligned.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pc=RESET_PC; state=START; pend_valid=0.
  - imem_req, if_valid, misaligned = 0; if_pc, if_instr = 0.
- Reset mid-request abandons it. Memory must ignore an ack that arrives after imem_req falls.
- States:
  - START: one cycle after reset release, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
  - OUT: if_valid=1.
  - TRAP: terminal until reset.
- Redirect select: jalr_valid has priority over br_valid; target = selected *_target.
- Misaligned: a redirect whose target[1:0]!=0 is not applied. It sets misaligned=1 and goes to TRAP once no request is outstanding (in FETCH: on ack, data dropped).
- Handshake: imem_addr must stay stable while imem_req=1 and the ack has not arrived.
- FETCH, no ack, redirect:
  - Latch pend_target=target, pend_valid=1; the latest redirect overwrites.
  - imem_addr unchanged.
- FETCH, ack, (pend_valid or redirect this cycle):
  - Drop imem_rdata.
  - pc = redirect-this-cycle target if present, else pend_target.
  - pend_valid=0; stay in FETCH. The new address is driven the next cycle.
- FETCH, ack, no redirect:
  - if_pc=pc, if_instr=imem_rdata, pc=pc+4; go to OUT.
  - Ack-to-if_valid latency is 1 cycle. Minimum 2 cycles per instruction; no back-to-back fetch.
- OUT, redirect (any if_ready):
  - if_valid=0 next cycle; pc=target; go to FETCH.
  - The presented instruction counts as consumed only if if_ready=1 that cycle. The redirect still wins for the next PC.
- OUT, if_ready=1, no redirect: go to FETCH at pc (already +4).
- OUT, if_ready=0: hold if_valid, if_pc, if_instr stable.
- TRAP: imem_req=0, if_valid=0, redirects ignored.
- Redirects in START are latched as pending and applied on FETCH entry, replacing RESET_PC.
- pc+4 wraps modulo 2^WORD_SIZE: 32'hFFFF_FFFC -> 32'h0000_0000.

Decomposition:
- Shared package core_pkg:
  - WORD_SIZE.
  - INSTR_BYTES=4.
  - fetch_state_t enum {START, FETCH, OUT, TRAP}.
- Sub-module next_pc_sel (combinational):
  - Inputs: jalr/br valid+target, pend_valid/pend_target, pc.
  - Outputs: chosen next PC, redirect_hit, misaligned_hit.
  - Remainder is a single FSM with registers.

Test Plan:
- Reset, ack 1 cycle after req, if_ready=1 -> imem_addr sequence 0x0,0x4,0x8. if_pc matches each address; if_instr equals returned rdata; if_valid 1 cycle after each ack.
- if_ready=0 for 3 cycles in OUT -> if_valid, if_pc, if_instr held stable; no imem_req until if_ready=1.
- jalr_valid=1, jalr_target=0x100 while FETCH for 0x8 awaits ack (ack 2 cycles later) -> imem_addr stays 0x8 until ack; rdata dropped (no if_valid); next req at 0x100.
- jalr_valid and br_valid together (0x200 / 0x300) in OUT -> next imem_addr=0x200; if_valid deasserts next cycle.
- br_valid, br_target=0x102 -> misaligned=1, state TRAP, imem_req stays 0; later redirects ignored; reset_n=0 clears misaligned.
- pc=0xFFFF_FFFC fetched and accepted -> next imem_addr=0x0000_0000.
